multi_voice_gen: RTL and testbench

- Parametrised, time-multiplexed oscillator bank for NUM_VOICES voices. One voice is computed per start/done transaction.
- Per-voice phase accumulator and 23-bit noise LFSR are held in internal state arrays.
- Adds to the fixed 3-voice generator: parametrised widths and voice count, SID-style combined waveforms (bitwise AND), a test bit, a registered output with voice-index echo, and out-of-range index error reporting.
- Sits between the register file/sequencer (which issues one start per voice per sample tick) and the envelope/mixer stage.

---
 rtl/multi_voice_pkg.sv | 36 +++
 rtl/multi_voice_gen_shaper.sv | 43 ++++
 rtl/multi_voice_gen.sv | 147 ++++++++++++++
 tb/tb_multi_voice_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_voice_pkg.sv
// Shared types and constants for the time-multiplexed oscillator bank.
package multi_voice_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WRITE
    } state_e;

    localparam int unsigned WAVE_TRI   = 0;
    localparam int unsigned WAVE_SAW   = 1;
    localparam int unsigned WAVE_PULSE = 2;
    localparam int unsigned WAVE_NOISE = 3;

    localparam int unsigned        LFSR_W     = 23;
    localparam logic [LFSR_W-1:0]  LFSR_SEED  = 23'h7FFFFF;
    localparam int unsigned        LFSR_TAP_A = 22;
    localparam int unsigned        LFSR_TAP_B = 17;

    // Noise output taps, n7 in the top field down to n0 in the bottom field.
    localparam logic [8*5-1:0] NOISE_TAPS = {5'd20, 5'd18, 5'd14, 5'd11, 5'd9, 5'd5, 5'd2, 5'd0};

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B]};
    endfunction

    function automatic logic [7:0] noise_bits(input logic [LFSR_W-1:0] l);
        logic [7:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n[i] = l[NOISE_TAPS[i*5 +: 5]];
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_voice_gen_shaper.sv
// Combinational waveform shaper: builds tri/saw/pulse/noise from the new phase and ANDs the selection.
module voice_wave_shaper
    import multi_voice_pkg::*;
#(
    parameter int unsigned PHASE_W = 19,
    parameter int unsigned PW_W    = 12,
    parameter int unsigned OUT_W   = 10
) (
    input  logic [PHASE_W-1:0]      nxt_i,
    input  logic                    prev_msb_i,
    input  logic [LFSR_W-1:0]       lfsr_i,
    input  logic [PW_W-1:0]         pw_i,
    input  logic [3:0]              sel_i,
    input  logic                    ring_i,
    input  logic                    test_i,
    output logic signed [OUT_W-1:0] wave_o
);

    localparam logic [OUT_W-1:0] SIGN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0] saw_w, tri_x, tri_w, pulse_w, noise_w, acc;
    logic [7:0]       nb;
    logic             fold;

    always_comb begin
        saw_w   = nxt_i[PHASE_W-1 -: OUT_W];
        tri_x   = nxt_i[PHASE_W-2 -: OUT_W];
        fold    = ring_i ? (nxt_i[PHASE_W-1] ^ prev_msb_i) : nxt_i[PHASE_W-1];
        tri_w   = (fold ? ~tri_x : tri_x) ^ SIGN;
        pulse_w = ((nxt_i[PHASE_W-1 -: PW_W] >= pw_i) || test_i) ? ~SIGN : SIGN;
        nb      = noise_bits(lfsr_i);
        noise_w = '0;
        noise_w[OUT_W-1 -: 8] = {~nb[7], nb[6:0]};

        acc = '1;
        if (sel_i[WAVE_TRI])   acc &= tri_w;
        if (sel_i[WAVE_SAW])   acc &= saw_w;
        if (sel_i[WAVE_PULSE]) acc &= pulse_w;
        if (sel_i[WAVE_NOISE]) acc &= noise_w;
        wave_o = (sel_i == '0) ? '0 : $signed(acc);
    end

endmodule

// File: rtl/multi_voice_gen.sv
// Time-multiplexed oscillator bank: one voice per start/done transaction, state held per voice.
module multi_voice_gen
    import multi_voice_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned PHASE_W    = 19,
    parameter int unsigned FREQ_W     = 16,
    parameter int unsigned PW_W       = 12,
    parameter int unsigned OUT_W      = 10,
    parameter int unsigned NOISE_BIT  = PHASE_W - 10,
    localparam int unsigned VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [VIDX_W-1:0]       voice_i,
    input  logic [FREQ_W-1:0]       freq_word_i,
    input  logic [PW_W-1:0]         pw_word_i,
    input  logic [3:0]              wave_sel_i,
    input  logic                    sync_i,
    input  logic                    ring_mod_i,
    input  logic                    test_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [VIDX_W-1:0]       voice_o,
    output logic signed [OUT_W-1:0] wave_o
);

    state_e                  state_q;
    logic [VIDX_W-1:0]       snap_voice_q;
    logic [FREQ_W-1:0]       snap_freq_q;
    logic [PW_W-1:0]         snap_pw_q;
    logic [3:0]              snap_sel_q;
    logic                    snap_sync_q, snap_ring_q, snap_test_q;

    logic [PHASE_W-1:0]      phase_q [NUM_VOICES];
    logic [LFSR_W-1:0]       lfsr_q  [NUM_VOICES];
    logic [1:0]              hist_q  [NUM_VOICES];

    logic                    busy_q, done_q, err_q;
    logic [VIDX_W-1:0]       voice_q;
    logic signed [OUT_W-1:0] wave_q;

    logic                    in_range;
    logic [VIDX_W-1:0]       vidx, pidx;
    logic [PHASE_W-1:0]      cur, nxt_d;
    logic [LFSR_W-1:0]       lfsr_d;
    logic signed [OUT_W-1:0] shaped;

    // Out-of-range indices are folded onto voice 0 for reads only; writes are gated by in_range.
    always_comb begin
        in_range = 32'(snap_voice_q) < NUM_VOICES;
        vidx     = in_range ? snap_voice_q : '0;
        pidx     = (vidx == '0) ? VIDX_W'(NUM_VOICES - 1) : vidx - VIDX_W'(1);
        cur      = phase_q[vidx];
        nxt_d    = cur + PHASE_W'(snap_freq_q);
        if (snap_sync_q && hist_q[pidx] == 2'b01) nxt_d = '0;
        if (snap_test_q) nxt_d = '0;
        lfsr_d = lfsr_q[vidx];
        if (snap_test_q) begin
            lfsr_d = LFSR_SEED;
        end else if (!cur[NOISE_BIT] && nxt_d[NOISE_BIT]) begin
            lfsr_d = lfsr_step(lfsr_q[vidx]);
        end
    end

    voice_wave_shaper #(
        .PHASE_W (PHASE_W),
        .PW_W    (PW_W),
        .OUT_W   (OUT_W)
    ) u_shaper (
        .nxt_i      (nxt_d),
        .prev_msb_i (phase_q[pidx][PHASE_W-1]),
        .lfsr_i     (lfsr_q[vidx]),
        .pw_i       (snap_pw_q),
        .sel_i      (snap_sel_q),
        .ring_i     (snap_ring_q),
        .test_i     (snap_test_q),
        .wave_o     (shaped)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            snap_voice_q <= '0;
            snap_freq_q  <= '0;
            snap_pw_q    <= '0;
            snap_sel_q   <= '0;
            snap_sync_q  <= 1'b0;
            snap_ring_q  <= 1'b0;
            snap_test_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            voice_q      <= '0;
            wave_q       <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                lfsr_q[i]  <= LFSR_SEED;
                hist_q[i]  <= 2'b00;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        snap_voice_q <= voice_i;
                        snap_freq_q  <= freq_word_i;
                        snap_pw_q    <= pw_word_i;
                        snap_sel_q   <= wave_sel_i;
                        snap_sync_q  <= sync_i;
                        snap_ring_q  <= ring_mod_i;
                        snap_test_q  <= test_i;
                        busy_q       <= 1'b1;
                        state_q      <= S_CALC;
                    end
                end
                S_CALC: state_q <= S_WRITE;
                S_WRITE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    voice_q <= snap_voice_q;
                    if (in_range) begin
                        phase_q[vidx] <= nxt_d;
                        hist_q[vidx]  <= {hist_q[vidx][0], nxt_d[PHASE_W-1]};
                        lfsr_q[vidx]  <= lfsr_d;
                        wave_q        <= shaped;
                    end else begin
                        wave_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign voice_o = voice_q;
    assign wave_o  = wave_q;

endmodule

// File: tb/tb_multi_voice_gen.sv
// Directed self-checking bench for multi_voice_gen with hand-computed expectations.
module tb_multi_voice_gen;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        voice = '0;
    logic [15:0]       freq = '0;
    logic [11:0]       pw = '0;
    logic [3:0]        sel = '0;
    logic              sync = 1'b0, ring = 1'b0, test = 1'b0;
    logic              busy, done, err;
    logic [1:0]        voice_out;
    logic signed [9:0] wave;

    int n_cmp = 0;
    int n_bad = 0;

    multi_voice_gen #(
        .NUM_VOICES (3),
        .PHASE_W    (19),
        .FREQ_W     (16),
        .PW_W       (12),
        .OUT_W      (10)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .voice_i     (voice),
        .freq_word_i (freq),
        .pw_word_i   (pw),
        .wave_sel_i  (sel),
        .sync_i      (sync),
        .ring_mod_i  (ring),
        .test_i      (test),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .voice_o     (voice_out),
        .wave_o      (wave)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        start = 1'b0; voice = '0; freq = '0; pw = '0; sel = '0;
        sync = 1'b0; ring = 1'b0; test = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drives one transaction and waits (bounded) for done; lat counts cycles from start drive to done.
    task automatic issue(input int v, input int f, input int p, input int s, input int sy,
                         input int rg, input int ts, output logic signed [9:0] w,
                         output logic [1:0] vo, output logic er, output int lat);
        @(posedge clk); #1;
        voice = 2'(v); freq = 16'(f); pw = 12'(p); sel = 4'(s);
        sync = 1'(sy); ring = 1'(rg); test = 1'(ts); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 8) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: no done_o within %0d cycles, required 3", lat);
        end
        w = wave; vo = voice_out; er = err;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", err); end
        n_cmp++; if (voice_out !== 2'd0) begin n_bad++; $display("FAIL rst_voice: got %0d expected 0", voice_out); end
        n_cmp++; if (wave !== 10'sd0) begin n_bad++; $display("FAIL rst_wave: got %0d expected 0", wave); end
    endtask

    task automatic test_saw();
        int cyc, busy_cnt;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            voice = 2'd0; freq = 16'h1000; sel = 4'b0010; pw = '0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc = 1; busy_cnt = 0;
            while (done !== 1'b1 && cyc < 8) begin
                if (busy === 1'b1) busy_cnt++;
                @(posedge clk); #1;
                cyc++;
            end
            n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL saw_latency[%0d]: got %0d expected 3", k, cyc); end
            n_cmp++; if (busy_cnt != 2) begin n_bad++; $display("FAIL saw_busy[%0d]: got %0d expected 2", k, busy_cnt); end
            n_cmp++; if (wave !== 10'(8 * k)) begin n_bad++; $display("FAIL saw_wave[%0d]: got %0d expected %0d", k, wave, 8 * k); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL saw_err[%0d]: got %b expected 0", k, err); end
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL saw_done_pulse[%0d]: got %b expected 0", k, done); end
            n_cmp++; if (wave !== 10'(8 * k)) begin n_bad++; $display("FAIL saw_hold[%0d]: got %0d expected %0d", k, wave, 8 * k); end
        end
    endtask

    task automatic test_pulse();
        logic signed [9:0] w; logic [1:0] vo; logic er; int lat; int exp_w;
        do_reset();
        // Eight steps of 0x8000 give phase[18:7] = 0x100..0x800; only the last reaches pw.
        for (int k = 1; k <= 8; k++) begin
            issue(0, 16'h8000, 12'h800, 4'b0100, 0, 0, 0, w, vo, er, lat);
            exp_w = (k == 8) ? 511 : -512;
            n_cmp++; if (w !== 10'(exp_w)) begin n_bad++; $display("FAIL pulse_wave[%0d]: got %0d expected %0d", k, w, exp_w); end
        end
        issue(1, 0, 0, 4'b0100, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd511) begin n_bad++; $display("FAIL pulse_pw0: got %0d expected 511", w); end
    endtask

    task automatic test_sync();
        logic signed [9:0] w; logic [1:0] vo; logic er; int lat;
        do_reset();
        repeat (2) issue(1, 16'h8000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        repeat (8) issue(0, 16'h8000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        issue(1, 16'h8000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd192) begin n_bad++; $display("FAIL sync_off: got %0d expected 192", w); end
        n_cmp++; if (vo !== 2'd1) begin n_bad++; $display("FAIL sync_voice_echo: got %0d expected 1", vo); end
        issue(1, 16'h8000, 0, 4'b0010, 1, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd0) begin n_bad++; $display("FAIL sync_on: got %0d expected 0", w); end
        issue(1, 16'h8000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd64) begin n_bad++; $display("FAIL sync_after: got %0d expected 64", w); end
        issue(0, 16'h8000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        issue(1, 16'h8000, 0, 4'b0010, 1, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd128) begin n_bad++; $display("FAIL sync_hist11: got %0d expected 128", w); end
    endtask

    task automatic test_ring();
        logic signed [9:0] w; logic [1:0] vo; logic er; int lat;
        do_reset();
        repeat (8) issue(0, 16'h8000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        issue(1, 16'h0100, 0, 4'b0001, 0, 1, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd510) begin n_bad++; $display("FAIL ring_on: got %0d expected 510", w); end
        issue(1, 0, 0, 4'b0001, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== -10'sd511) begin n_bad++; $display("FAIL ring_off: got %0d expected -511", w); end
    endtask

    task automatic test_combined();
        logic signed [9:0] w; logic [1:0] vo; logic er; int lat;
        do_reset();
        issue(0, 16'hC000, 0, 4'b0011, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd64) begin n_bad++; $display("FAIL comb_tri_saw: got %0d expected 64", w); end
        issue(0, 16'h1234, 12'hFFF, 4'b0100, 0, 0, 1, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd511) begin n_bad++; $display("FAIL test_pulse: got %0d expected 511", w); end
        issue(0, 16'h1000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd8) begin n_bad++; $display("FAIL test_phase0: got %0d expected 8", w); end
        issue(2, 16'h0200, 0, 4'b1000, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd508) begin n_bad++; $display("FAIL noise_seed: got %0d expected 508", w); end
        issue(2, 16'h0200, 0, 4'b1000, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd504) begin n_bad++; $display("FAIL noise_step: got %0d expected 504", w); end
        issue(2, 16'h0200, 0, 4'b0100, 0, 0, 1, w, vo, er, lat);
        issue(2, 0, 0, 4'b1000, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd508) begin n_bad++; $display("FAIL noise_test_reseed: got %0d expected 508", w); end
        issue(2, 16'h0100, 0, 4'b0000, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd0) begin n_bad++; $display("FAIL sel_none: got %0d expected 0", w); end
    endtask

    task automatic test_error();
        logic signed [9:0] w; logic [1:0] vo; logic er; int lat;
        do_reset();
        issue(0, 16'h1000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        issue(3, 16'h1000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b expected 1", er); end
        n_cmp++; if (w !== 10'sd0) begin n_bad++; $display("FAIL err_wave: got %0d expected 0", w); end
        n_cmp++; if (vo !== 2'd3) begin n_bad++; $display("FAIL err_voice: got %0d expected 3", vo); end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL err_latency: got %0d expected 3", lat); end
        @(posedge clk); #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pulse: got %b expected 0", err); end
        issue(0, 16'h1000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd16) begin n_bad++; $display("FAIL err_no_update: got %0d expected 16", w); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b expected 0", er); end
    endtask

    task automatic test_back_to_back();
        int dones;
        do_reset();
        @(posedge clk); #1;
        voice = 2'd0; freq = 16'h1000; sel = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL calc_start_ignored: got %0d dones expected 1", dones); end
        n_cmp++; if (wave !== 10'sd8) begin n_bad++; $display("FAIL calc_start_wave: got %0d expected 8", wave); end
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
            if (i == 8) start = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_cmp++; if (dones != 3) begin n_bad++; $display("FAIL b2b_dones: got %0d expected 3", dones); end
        n_cmp++; if (wave !== 10'sd32) begin n_bad++; $display("FAIL b2b_wave: got %0d expected 32", wave); end
    endtask

    task automatic test_reset_write();
        logic signed [9:0] w; logic [1:0] vo; logic er; int lat; int dones;
        do_reset();
        issue(1, 16'h1000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (vo !== 2'd1) begin n_bad++; $display("FAIL rw_pre_voice: got %0d expected 1", vo); end
        @(posedge clk); #1;
        voice = 2'd0; freq = 16'h1000; sel = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rw_busy: got %b expected 0", busy); end
        n_cmp++; if (wave !== 10'sd0) begin n_bad++; $display("FAIL rw_wave: got %0d expected 0", wave); end
        n_cmp++; if (voice_out !== 2'd0) begin n_bad++; $display("FAIL rw_voice: got %0d expected 0", voice_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rw_no_done: got %0d dones expected 0", dones); end
        issue(0, 16'h1000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd8) begin n_bad++; $display("FAIL rw_v0_restart: got %0d expected 8", w); end
        issue(1, 16'h1000, 0, 4'b0010, 0, 0, 0, w, vo, er, lat);
        n_cmp++; if (w !== 10'sd8) begin n_bad++; $display("FAIL rw_v1_restart: got %0d expected 8", w); end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_pulse();
        test_sync();
        test_ring();
        test_combined();
        test_error();
        test_back_to_back();
        test_reset_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
